ex_stage: RTL

//  Execute stage sitting directly downstream of the Decode/Execute pipeline latch. Resolves operand

---
 rtl/ex_stage_if.sv | 69 ++++++
 rtl/ex_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_if.sv
// Execute-stage bundle: D/Ex latch fields, forwarding taps and Ex/Mem latch outputs.
// The upstream side (decode latch / bench) uses master, the stage itself uses slave.
interface ex_stage_if #(
    parameter int DW = 8,
    parameter int AW = 2
);
    logic          ld;
    logic          flush;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [DW-1:0] r_ra;
    logic [DW-1:0] r_rb;
    logic [DW-1:0] imm;
    logic [3:0]    alu;
    logic [4:0]    flags;
    logic [2:0]    bu;
    logic          se1;
    logic          se2;
    logic          rw;
    logic          mw;
    logic          sw1;
    logic          sw2;
    logic          sm1;
    logic          sm2;
    logic          out_ld;
    logic [1:0]    sp;
    logic [1:0]    se3;
    logic          intr;
    logic          em_rw;
    logic          mw_rw;
    logic [AW-1:0] em_rd;
    logic [AW-1:0] mw_rd;
    logic [DW-1:0] em_data;
    logic [DW-1:0] mw_data;

    logic [3:0]    ccr;
    logic          br_taken;
    logic [DW-1:0] br_target;
    logic [DW-1:0] x_result;
    logic [DW-1:0] x_store;
    logic [AW-1:0] x_rd;
    logic          x_rw;
    logic          x_mw;
    logic          x_sw1;
    logic          x_sw2;
    logic          x_sm1;
    logic          x_sm2;
    logic          x_out_ld;
    logic [1:0]    x_sp;
    logic [1:0]    x_se3;

    modport master (
        output ld, flush, ra, rb, r_ra, r_rb, imm, alu, flags, bu,
        output se1, se2, rw, mw, sw1, sw2, sm1, sm2, out_ld, sp, se3,
        output intr, em_rw, mw_rw, em_rd, mw_rd, em_data, mw_data,
        input  ccr, br_taken, br_target, x_result, x_store, x_rd,
        input  x_rw, x_mw, x_sw1, x_sw2, x_sm1, x_sm2, x_out_ld,
        input  x_sp, x_se3
    );

    modport slave (
        input  ld, flush, ra, rb, r_ra, r_rb, imm, alu, flags, bu,
        input  se1, se2, rw, mw, sw1, sw2, sm1, sm2, out_ld, sp, se3,
        input  intr, em_rw, mw_rw, em_rd, mw_rd, em_data, mw_data,
        output ccr, br_taken, br_target, x_result, x_store, x_rd,
        output x_rw, x_mw, x_sw1, x_sw2, x_sm1, x_sm2, x_out_ld,
        output x_sp, x_se3
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, CCR {V,C,N,Z} with interrupt save/restore,
// branch evaluation and the registered Ex/Mem boundary latch.
module ex_stage #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic        clk,
    input  logic        reset,
    ex_stage_if.slave   bus
);

    typedef enum logic [3:0] {
        OP_MOV  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_RLC  = 4'h5,
        OP_RRC  = 4'h6,
        OP_SETC = 4'h7,
        OP_CLRC = 4'h8,
        OP_NOT  = 4'h9,
        OP_NEG  = 4'hA,
        OP_INC  = 4'hB,
        OP_DEC  = 4'hC,
        OP_PASS = 4'hD,
        OP_RSV0 = 4'hE,
        OP_RSV1 = 4'hF
    } alu_op_e;

    typedef struct packed {
        logic [DW-1:0] result;
        logic [DW-1:0] store;
        logic [AW-1:0] rd;
        logic          rw;
        logic          mw;
        logic          sw1;
        logic          sw2;
        logic          sm1;
        logic          sm2;
        logic          out_ld;
        logic [1:0]    sp;
        logic [1:0]    se3;
    } x_t;

    logic [3:0]    ccr_q, ccr_d;
    logic [3:0]    saved_q, saved_d;
    x_t            x_q, x_d;

    logic [DW-1:0] fa, fb;
    logic [DW-1:0] opa, opb;
    logic [DW-1:0] ax, ay;
    logic          cin;
    logic          arith;
    logic          rsv;
    logic [DW:0]   sum;
    logic [DW-1:0] res;
    logic          c_new;
    logic          v_new;
    logic [3:0]    nf;
    logic          taken;
    logic [3:0]    clr;

    always_comb begin
        fa = bus.r_ra;
        if (bus.em_rw && bus.em_rd == bus.ra)
            fa = bus.em_data;
        else if (bus.mw_rw && bus.mw_rd == bus.ra)
            fa = bus.mw_data;
    end

    always_comb begin
        fb = bus.r_rb;
        if (bus.em_rw && bus.em_rd == bus.rb)
            fb = bus.em_data;
        else if (bus.mw_rw && bus.mw_rd == bus.rb)
            fb = bus.mw_data;
    end

    assign opa = bus.se1 ? bus.imm : fa;
    assign opb = bus.se2 ? bus.imm : fb;

    // Subtractions are A + ~B + 1, so the carry out is the no-borrow flag.
    always_comb begin
        ax    = '0;
        ay    = '0;
        cin   = 1'b0;
        arith = 1'b0;
        rsv   = 1'b0;
        res   = '0;
        c_new = ccr_q[2];
        unique case (alu_op_e'(bus.alu))
            OP_MOV:  res = opb;
            OP_ADD: begin
                ax = opa; ay = opb; arith = 1'b1;
            end
            OP_SUB: begin
                ax = opa; ay = ~opb; cin = 1'b1; arith = 1'b1;
            end
            OP_AND:  res = opa & opb;
            OP_OR:   res = opa | opb;
            OP_RLC: begin
                res   = {opa[DW-2:0], ccr_q[2]};
                c_new = opa[DW-1];
            end
            OP_RRC: begin
                res   = {ccr_q[2], opa[DW-1:1]};
                c_new = opa[0];
            end
            OP_SETC: begin
                res = opa; c_new = 1'b1;
            end
            OP_CLRC: begin
                res = opa; c_new = 1'b0;
            end
            OP_NOT:  res = ~opa;
            OP_NEG: begin
                ay = ~opa; cin = 1'b1; arith = 1'b1;
            end
            OP_INC: begin
                ax = opa; cin = 1'b1; arith = 1'b1;
            end
            OP_DEC: begin
                ax = opa; ay = '1; arith = 1'b1;
            end
            OP_PASS: res = opa;
            OP_RSV0, OP_RSV1: rsv = 1'b1;
        endcase
        sum = {1'b0, ax} + {1'b0, ay} + {{DW{1'b0}}, cin};
        if (arith) begin
            res   = sum[DW-1:0];
            c_new = sum[DW];
        end
        v_new = arith && (ax[DW-1] == ay[DW-1]) &&
                (res[DW-1] != ax[DW-1]);
        nf = rsv ? ccr_q :
             {v_new, c_new, res[DW-1], res == '0};
    end

    always_comb begin
        taken = 1'b0;
        clr   = 4'b0000;
        unique case (bus.bu)
            3'b001: begin taken = ccr_q[0]; clr = 4'b0001; end
            3'b010: begin taken = ccr_q[1]; clr = 4'b0010; end
            3'b011: begin taken = ccr_q[2]; clr = 4'b0100; end
            3'b100: begin taken = ccr_q[3]; clr = 4'b1000; end
            3'b101: taken = 1'b1;
            3'b110: taken = (fb != {{(DW-1){1'b0}}, 1'b1});
            3'b000, 3'b111: taken = 1'b0;
        endcase
    end

    // Interrupt snapshot takes the CCR as it was before this edge.
    always_comb begin
        saved_d = saved_q;
        ccr_d   = ccr_q;
        if (bus.intr)
            saved_d = ccr_q;
        if (bus.ld && !bus.flush) begin
            if (bus.flags[4] && !bus.intr)
                ccr_d = saved_q;
            else
                ccr_d = (ccr_q & ~bus.flags[3:0]) |
                        (nf & bus.flags[3:0]);
            if (taken)
                ccr_d = ccr_d & ~clr;
        end
    end

    always_comb begin
        x_d = x_q;
        if (bus.flush) begin
            x_d = '0;
        end else if (bus.ld) begin
            x_d.result = res;
            x_d.store  = fa;
            x_d.rd     = bus.ra;
            x_d.rw     = bus.rw;
            x_d.mw     = bus.mw;
            x_d.sw1    = bus.sw1;
            x_d.sw2    = bus.sw2;
            x_d.sm1    = bus.sm1;
            x_d.sm2    = bus.sm2;
            x_d.out_ld = bus.out_ld;
            x_d.sp     = bus.sp;
            x_d.se3    = bus.se3;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ccr_q   <= '0;
            saved_q <= '0;
            x_q     <= '0;
        end else begin
            ccr_q   <= ccr_d;
            saved_q <= saved_d;
            x_q     <= x_d;
        end
    end

    assign bus.ccr       = ccr_q;
    assign bus.br_taken  = taken;
    assign bus.br_target = fb;
    assign bus.x_result  = x_q.result;
    assign bus.x_store   = x_q.store;
    assign bus.x_rd      = x_q.rd;
    assign bus.x_rw      = x_q.rw;
    assign bus.x_mw      = x_q.mw;
    assign bus.x_sw1     = x_q.sw1;
    assign bus.x_sw2     = x_q.sw2;
    assign bus.x_sm1     = x_q.sm1;
    assign bus.x_sm2     = x_q.sm2;
    assign bus.x_out_ld  = x_q.out_ld;
    assign bus.x_sp      = x_q.sp;
    assign bus.x_se3     = x_q.se3;

endmodule
